// File: rtl/req_arbiter.sv
// req_arbiter: round-robin consumer of NUM_PORTS request FIFOs.
//
// Each cycle with a grant opportunity (idle, or holding a packet that is being
// accepted), the first eligible FIFO head found from rr_ptr upward is popped
// and registered onto a valid/ready dispatch interface.
//
// Ports:
//   clk, rst_b              clock, asynchronous active-low reset
//   port_req[NUM_PORTS]     FIFO head packets (.req marks pending)
//   port_read[NUM_PORTS]    one-hot pop strobe, combinational
//   disp_valid/req/port     registered dispatch packet and its source port
//   disp_ready              execution stage accepts the dispatched packet
//   rsp_done/rsp_port       completion of one in-flight request
//   cred_err                sticky credit underflow / illegal rsp_port flag
//
// Optional feature macro: REQ_ARB_CREDIT_EN
//   defined   : per-port in-flight counters cap grants at MAX_OUTST
//   undefined : every pending port is eligible, rsp_* ignored, cred_err = 0

package req_arbiter_pkg;
    typedef struct packed {
        logic        req;
        logic [7:0]  opcode;
        logic [15:0] addr;
    } req_pkt_type;
endpackage

module req_arbiter
    import req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_OUTST = 2,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  req_pkt_type          port_req [NUM_PORTS],
    output logic [NUM_PORTS-1:0] port_read,
    output logic                 disp_valid,
    output req_pkt_type          disp_req,
    output logic [PORT_W-1:0]    disp_port,
    input  logic                 disp_ready,
    input  logic                 rsp_done,
    input  logic [PORT_W-1:0]    rsp_port,
    output logic                 cred_err
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t              state_q, state_d;
    req_pkt_type         pkt_q, pkt_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0] elig;
    logic [PORT_W:0]      search;
    logic                 grant;
    logic [PORT_W-1:0]    grant_idx;

    // Returns {found, index} of the first set bit of el, scanning from start
    // upward with wrap.
    function automatic logic [PORT_W:0] rr_search(input logic [NUM_PORTS-1:0] el,
                                                  input logic [PORT_W-1:0]    start);
        logic [PORT_W:0] r;
        int              idx;
        r = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(start) + k) % NUM_PORTS;
            if (!r[PORT_W] && el[PORT_W'(idx)]) r = {1'b1, PORT_W'(idx)};
        end
        return r;
    endfunction

`ifdef REQ_ARB_CREDIT_EN
    logic [3:0] outst_q [NUM_PORTS];
    logic [3:0] outst_d [NUM_PORTS];
    logic       cred_err_q, cred_err_d;
    logic       rsp_ok;

    // Eligibility looks only at registered counters; a response in the same
    // cycle frees its credit for the following cycle.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            elig[i] = port_req[i].req && (outst_q[i] < 4'(MAX_OUTST));
    end

    assign rsp_ok = rsp_done && (int'(rsp_port) < NUM_PORTS) && (outst_q[rsp_port] != 4'd0);

    always_comb begin
        cred_err_d = cred_err_q | (rsp_done & ~rsp_ok);
        for (int i = 0; i < NUM_PORTS; i++) begin
            outst_d[i] = outst_q[i];
            if (grant && (int'(grant_idx) == i))               outst_d[i] = outst_d[i] + 4'd1;
            if (rsp_ok && (int'(rsp_port) == i))               outst_d[i] = outst_d[i] - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cred_err_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) outst_q[i] <= 4'd0;
        end else begin
            cred_err_q <= cred_err_d;
            for (int i = 0; i < NUM_PORTS; i++) outst_q[i] <= outst_d[i];
        end
    end

    assign cred_err = cred_err_q;
`else
    logic unused_rsp;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) elig[i] = port_req[i].req;
    end

    assign unused_rsp = ^{rsp_done, rsp_port};
    assign cred_err   = 1'b0;
`endif

    // Outputs are registered, so an incoming disp_ready only matters while HOLD.
    assign search    = rr_search(elig, rr_ptr_q);
    assign grant     = search[PORT_W] && ((state_q == IDLE) || disp_ready);
    assign grant_idx = search[PORT_W-1:0];

    always_comb begin
        port_read = '0;
        if (grant && rst_b) port_read[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        port_d   = port_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            state_d  = HOLD;
            pkt_d    = port_req[grant_idx];
            port_d   = grant_idx;
            rr_ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PORT_W'(1);
        end else if ((state_q == HOLD) && disp_ready) begin
            state_d = IDLE;
            pkt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            port_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            port_q   <= port_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign disp_valid = (state_q == HOLD);
    assign disp_req   = pkt_q;
    assign disp_port  = port_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
module tb_req_arbiter;
    import req_arbiter_pkg::*;

    localparam int NP    = 4;
    localparam int MAXO  = 2;
    localparam int PW    = 2;

    logic              clk;
    logic              rst_b;
    req_pkt_type       preq [NP];
    logic [NP-1:0]     port_read;
    logic              disp_valid;
    req_pkt_type       disp_req;
    logic [PW-1:0]     disp_port;
    logic              disp_ready;
    logic              rsp_done;
    logic [PW-1:0]     rsp_port;
    logic              cred_err;

    req_arbiter #(.NUM_PORTS(NP), .MAX_OUTST(MAXO)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .port_req   (preq),
        .port_read  (port_read),
        .disp_valid (disp_valid),
        .disp_req   (disp_req),
        .disp_port  (disp_port),
        .disp_ready (disp_ready),
        .rsp_done   (rsp_done),
        .rsp_port   (rsp_port),
        .cred_err   (cred_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: "what the dispatch register holds" plus credit book-keeping.
    logic        m_valid;
    req_pkt_type m_pkt;
    int          m_port;
    int          m_ptr;
    int          m_out [NP];
    logic        m_err;
    logic [NP-1:0] last_read;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pkt   = '0;
        m_port  = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        for (int i = 0; i < NP; i++) m_out[i] = 0;
    endtask

    function automatic bit m_eligible(input int p);
`ifdef REQ_ARB_CREDIT_EN
        return preq[p].req && (m_out[p] < MAXO);
`else
        return preq[p].req;
`endif
    endfunction

    // First eligible port walking upward from the pointer, -1 if none.
    function automatic int model_pick();
        for (int k = 0; k < NP; k++) begin
            int p = (m_ptr + k) % NP;
            if (m_eligible(p)) return p;
        end
        return -1;
    endfunction

    task automatic set_req(input logic [NP-1:0] mask);
        for (int i = 0; i < NP; i++) begin
            preq[i].req    = mask[i];
            preq[i].opcode = 8'($urandom);
            preq[i].addr   = 16'($urandom);
        end
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle,
    // advances the model across the rising edge, returns at the next falling edge.
    task automatic step();
        int            g;
        logic [NP-1:0] exp_read;
        #1;
        g = (!m_valid || disp_ready) ? model_pick() : -1;
        exp_read = '0;
        if (g >= 0) exp_read[PW'(g)] = 1'b1;
        last_read = port_read;
        chk("port_read",  64'(port_read),  64'(exp_read));
        chk("disp_valid", 64'(disp_valid), 64'(m_valid));
        chk("disp_port",  64'(disp_port),  64'(m_port));
        chk("disp_req",   64'(disp_req),   64'(m_pkt));
        chk("cred_err",   64'(cred_err),   64'(m_err));
        @(posedge clk);
`ifdef REQ_ARB_CREDIT_EN
        if (rsp_done) begin
            if (int'(rsp_port) >= NP || m_out[rsp_port] == 0) m_err = 1'b1;
            else m_out[rsp_port] = m_out[rsp_port] - 1;
        end
        if (g >= 0) m_out[g] = m_out[g] + 1;
`endif
        if (g >= 0) begin
            m_valid = 1'b1;
            m_pkt   = preq[g];
            m_port  = g;
            m_ptr   = (g + 1) % NP;
        end else if (m_valid && disp_ready) begin
            m_valid = 1'b0;
            m_pkt   = '0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int grants;

    initial begin
        rst_b      = 1'b0;
        disp_ready = 1'b0;
        rsp_done   = 1'b0;
        rsp_port   = '0;
        set_req(4'b1111);
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset with everything pending.
        #1;
        chk("rst_valid", 64'(disp_valid), 64'(0));
        chk("rst_read",  64'(port_read),  64'(0));
        chk("rst_req",   64'(disp_req),   64'(0));
        chk("rst_err",   64'(cred_err),   64'(0));
        @(negedge clk);
        rst_b = 1'b1;

        // Round-robin with all ports pending and always ready.
        disp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(4'b1111);
            step();
            chk("rr_seq",   64'(disp_port),  64'(rr_exp[i]));
            chk("rr_valid", 64'(disp_valid), 64'(1));
        end

        // Backpressure on a port-2 packet.
        do_reset();
        set_req(4'b0110);
        step();
        step();
        chk("bp_first", 64'(disp_port), 64'(2));
        disp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(4'b1111);
            step();
            chk("bp_hold", 64'(disp_port), 64'(2));
            chk("bp_read", 64'(last_read), 64'(0));
        end
        disp_ready = 1'b1;
        step();
        chk("bp_next_read", 64'(last_read), 64'(4'b1000));
        chk("bp_next_port", 64'(disp_port), 64'(3));

        // Wrap/skip: pointer at 2 with only ports 1 and 3 pending.
        do_reset();
        set_req(4'b0010);
        step();
        set_req(4'b1010);
        step();
        chk("wrap_3", 64'(disp_port), 64'(3));
        step();
        chk("wrap_1", 64'(disp_port), 64'(1));

`ifdef REQ_ARB_CREDIT_EN
        // Credit cap on a single port, then release by response.
        do_reset();
        set_req(4'b0001);
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_read[0]) grants++;
        end
        chk("cred_grants", 64'(grants), 64'(2));
        chk("cred_idle",   64'(disp_valid), 64'(0));
        rsp_done = 1'b1;
        rsp_port = 2'd0;
        step();
        chk("cred_no_bypass", 64'(last_read), 64'(0));
        rsp_done = 1'b0;
        step();
        chk("cred_third", 64'(last_read), 64'(4'b0001));
        rsp_done = 1'b1;
        rsp_port = 2'd3;
        step();
        rsp_done = 1'b0;
        step();
        chk("cred_err_set", 64'(cred_err), 64'(1));
        step();
        step();
        chk("cred_err_sticky", 64'(cred_err), 64'(1));
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_req(4'($urandom));
            disp_ready = ($urandom_range(0, 3) != 0);
            rsp_done   = ($urandom_range(0, 2) == 0);
            rsp_port   = PW'($urandom);
            step();
        end
        rsp_done = 1'b0;

        // Asynchronous reset while holding a packet.
        disp_ready = 1'b0;
        set_req(4'b1111);
        step();
        chk("mid_hold", 64'(disp_valid), 64'(1));
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(disp_valid), 64'(0));
        chk("mid_rst_read",  64'(port_read),  64'(0));
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        disp_ready = 1'b1;
        set_req(4'b1111);
        step();
        chk("mid_restart", 64'(disp_port), 64'(0));
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
